// File: rtl/program_memory_loader.sv
// Streams a byte image (16-bit word count N, then N big-endian words) into program memory
// while holding the CPU in reset. Define LOADER_CHECKSUM_EN to add a trailing checksum byte.
//
// state  | meaning
// IDLE   | after reset, waiting for Start
// HDR_HI | waiting for N[15:8]
// HDR_LO | waiting for N[7:0], header validated here
// DATA   | assembling a word, MSB byte first
// WRITE  | one-cycle write strobe for word k
// CHECK  | waiting for the checksum byte (LOADER_CHECKSUM_EN only)
// DONE   | image loaded, CPU released
// ERROR  | load aborted, CPU held
module program_memory_loader #(
  parameter int MEMORY_DEPTH = 256,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [7:0]            ByteData,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic                  CpuHold
);
  localparam int KW = $clog2(MEMORY_DEPTH) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
`ifdef LOADER_CHECKSUM_EN
    ,CHECK = 3'd7
`endif
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    hdr_hi;
  logic [KW-1:0] n_last;
  logic [KW-1:0] k;
  logic [1:0]    byte_cnt;
  logic [23:0]   shift;
  logic          accept;
  logic [15:0]   n_hdr;
  logic          hdr_bad;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum;
  logic          sum_ok;

  assign sum_ok = ((sum + ByteData) == 8'd0);
`endif

  assign accept  = ByteValid && ByteReady;
  assign n_hdr   = {hdr_hi, ByteData};
  assign hdr_bad = (n_hdr == 16'd0) || (32'(n_hdr) > 32'(MEMORY_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    ByteReady   = 1'b0;
    WriteEnable = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    Error       = 1'b0;
    CpuHold     = 1'b1;
    case (state)
      IDLE: begin
        if (Start) state_nx = HDR_HI;
      end
      HDR_HI: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
        if (ByteValid) state_nx = HDR_LO;
      end
      HDR_LO: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
        if (ByteValid) state_nx = hdr_bad ? ERROR : DATA;
      end
      DATA: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
        if (ByteValid && (byte_cnt == 2'd3)) state_nx = WRITE;
      end
      WRITE: begin
        WriteEnable = 1'b1;
        Busy        = 1'b1;
        if (k == n_last) begin
`ifdef LOADER_CHECKSUM_EN
          state_nx = CHECK;
`else
          state_nx = DONE;
`endif
        end else begin
          state_nx = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        ByteReady = 1'b1;
        Busy      = 1'b1;
        if (ByteValid) state_nx = sum_ok ? DONE : ERROR;
      end
`endif
      DONE: begin
        Done    = 1'b1;
        CpuHold = 1'b0;
        if (Start) state_nx = HDR_HI;
      end
      ERROR: begin
        Error = 1'b1;
        if (Start) state_nx = HDR_HI;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Write port registers are loaded on the 4th byte so they are stable for the whole WRITE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_hi       <= '0;
      n_last       <= '0;
      k            <= '0;
      byte_cnt     <= '0;
      shift        <= '0;
      WriteAddress <= '0;
      WriteData    <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (Start) begin
            k        <= '0;
            byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
          end
        end
        HDR_HI: begin
          if (accept) hdr_hi <= ByteData;
        end
        HDR_LO: begin
          if (accept) n_last <= KW'(n_hdr - 16'd1);
        end
        DATA: begin
          if (accept) begin
            shift    <= {shift[15:0], ByteData};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum      <= sum + ByteData;
`endif
            if (byte_cnt == 2'd3) begin
              WriteData    <= DATA_WIDTH'({shift, ByteData});
              WriteAddress <= DATA_WIDTH'({k, 2'b00});
            end
          end
        end
        WRITE: begin
          k <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed and randomized checks of program_memory_loader against an image-level reference model.
// Honours LOADER_CHECKSUM_EN in the same way as the design.
module tb_program_memory_loader;
  localparam int DEPTH = 256;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  ByteData = 8'h00;
  logic        ByteValid = 1'b0;
  logic        ByteReady, WriteEnable, Busy, Done, Error, CpuHold;
  logic [31:0] WriteAddress, WriteData;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  program_memory_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ByteData(ByteData), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
    .WriteData(WriteData), .Busy(Busy), .Done(Done), .Error(Error), .CpuHold(CpuHold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (WriteEnable) begin
      wq_addr.push_back(WriteAddress);
      wq_data.push_back(WriteData);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cpuhold"}, 32'(CpuHold), 32'd1);
    check({tag, "_ready"},   32'(ByteReady), 32'd0);
    check({tag, "_we"},      32'(WriteEnable), 32'd0);
    check({tag, "_done"},    32'(Done), 32'd0);
    check({tag, "_error"},   32'(Error), 32'd0);
    check({tag, "_busy"},    32'(Busy), 32'd0);
    check({tag, "_waddr"},   WriteAddress, 32'd0);
    check({tag, "_wdata"},   WriteData, 32'd0);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Entered and left at a falling edge with ByteValid low.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
    int guard;
    if (pulse) pulse_start();
    repeat (gap) @(negedge clk);
    ByteData  = b;
    ByteValid = 1'b1;
    guard = 0;
    while (ByteReady !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("byte_ready_wait", 32'(ByteReady), 32'd1);
    @(negedge clk);
    ByteValid = 1'b0;
  endtask

  function automatic bq_t make_image(input int n);
    bq_t q;
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    if (n >= 1 && n <= DEPTH) begin
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
      begin
        logic [7:0] s;
        s = 8'd0;
        for (int i = 2; i < q.size(); i++) s = s + q[i];
        q.push_back(8'd0 - s);
      end
`endif
    end
    return q;
  endfunction

  // Reference: header gives N; valid N yields writes (4k, word k) then Done (or checksum verdict).
  task automatic run_image(input bq_t img, input int gapmax, input int start_at, input string tag);
    int n;
    bit hdr_ok;
    bit exp_done;
    logic [31:0] w;
    n = int'(img[0]) * 256 + int'(img[1]);
    hdr_ok = (n >= 1) && (n <= DEPTH);
    exp_done = hdr_ok;
`ifdef LOADER_CHECKSUM_EN
    if (hdr_ok) begin
      logic [7:0] s;
      s = 8'd0;
      for (int i = 2; i < 2 + 4 * n + 1; i++) s = s + img[i];
      exp_done = (s == 8'd0);
    end
`endif
    pulse_start();
    wq_addr.delete();
    wq_data.delete();
    foreach (img[i]) begin
      send_byte(img[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, (i == start_at));
    end
    repeat (3) @(negedge clk);
    check({tag, "_write_count"}, 32'(wq_addr.size()), hdr_ok ? 32'(n) : 32'd0);
    if (hdr_ok) begin
      for (int k = 0; k < n && k < wq_addr.size(); k++) begin
        w = {img[2 + 4 * k], img[3 + 4 * k], img[4 + 4 * k], img[5 + 4 * k]};
        check({tag, "_addr"}, wq_addr[k], 32'(4 * k));
        check({tag, "_data"}, wq_data[k], w);
      end
    end
    check({tag, "_done"},    32'(Done), 32'(exp_done));
    check({tag, "_error"},   32'(Error), 32'(!exp_done));
    check({tag, "_cpuhold"}, 32'(CpuHold), 32'(!exp_done));
    check({tag, "_busy"},    32'(Busy), 32'd0);
    check({tag, "_ready"},   32'(ByteReady), 32'd0);
  endtask

  initial begin
    bq_t img;
    logic [31:0] ref_addr[$];
    logic [31:0] ref_data[$];
    int n;

    repeat (2) @(negedge clk);
    check_idle_outputs("in_reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("idle");

    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
`ifdef LOADER_CHECKSUM_EN
    img.push_back(8'h3A);
`endif
    run_image(img, 0, -1, "spec");
    check("spec_w0_addr", wq_addr[0], 32'h0);
    check("spec_w0_data", wq_data[0], 32'h2008_0005);
    check("spec_w1_addr", wq_addr[1], 32'h4);
    check("spec_w1_data", wq_data[1], 32'h8C09_0004);

    run_image('{8'h00, 8'h00}, 0, -1, "hdr_zero");
    run_image('{8'h01, 8'h01}, 0, -1, "hdr_257");
    n = int'($urandom_range(DEPTH + 1, 65535));
    run_image(make_image(n), 1, -1, "hdr_big");

    run_image(make_image(DEPTH), 0, -1, "full");
    check("full_last_addr", wq_addr[DEPTH - 1], 32'h3FC);

    img = make_image(5);
    run_image(img, 0, -1, "gapless");
    ref_addr = wq_addr;
    ref_data = wq_data;
    run_image(img, 4, int'($urandom_range(3, img.size() - 1)), "gaps_start");
    check("gaps_count_vs_gapless", 32'(wq_addr.size()), 32'(ref_addr.size()));
    for (int k = 0; k < ref_addr.size() && k < wq_addr.size(); k++) begin
      check("gaps_data_vs_gapless", wq_data[k], ref_data[k]);
    end

    for (int r = 0; r < 4; r++) begin
      run_image(make_image(int'($urandom_range(1, 9))), 2, -1, "random");
    end

    img = make_image(4);
    pulse_start();
    wq_addr.delete();
    wq_data.delete();
    for (int i = 0; i < 12; i++) send_byte(img[i], 0, 1'b0);
    check("pre_reset_writes", 32'(wq_addr.size()), 32'd2);
    #2 reset = 1'b1;
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");
    run_image(make_image(4), 1, -1, "reload");

`ifdef LOADER_CHECKSUM_EN
    run_image('{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF}, 0, -1, "csum_good");
    run_image('{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00}, 0, -1, "csum_bad");
    img = make_image(3);
    img[img.size() - 1] = img[img.size() - 1] + 8'($urandom_range(1, 255));
    run_image(img, 1, -1, "csum_rand_bad");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
